// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial load/store engine between a CPU request port
// and an 8-bit data memory. Loads and stores of 1, 2 or 4 bytes are moved
// one byte per cycle; load results are sign/zero-extended per RISC-V func3.
// Optional build macro: LSU_MISALIGN_TRAP_EN rejects misaligned halfword and
// word requests with resp_err instead of completing them byte-serially.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  state_t            state;
  logic              read_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt;
  logic [31:0]       result;

  logic [31:0]       merged;
  logic              req_reject;
  logic              misalign;

  // Index of the final byte of a transfer (N-1) for a given width code.
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // Sign/zero extension of assembled load data.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b010:  extend = d;
      3'b100:  extend = {24'd0, d[7:0]};
      3'b101:  extend = {16'd0, d[15:0]};
      default: extend = '0;
    endcase
  endfunction

  // Request legality: unsupported width codes and, optionally, misalignment.
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_func3[1:0] == 2'b01)
      misalign = req_addr[0];
    else if (req_func3[1:0] == 2'b10)
      misalign = (req_addr[1:0] != 2'b00);
`endif
    if (req_read)
      req_reject = !(req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      req_reject = !(req_func3 inside {3'b000, 3'b001, 3'b010});
    req_reject = req_reject | misalign;
  end

  // Load result with the byte arriving this cycle merged in, so the final
  // byte can be extended straight into the registered response.
  always_comb begin
    merged = result;
    if (read_q)
      merged[{cnt, 3'b000} +: 8] = mem_rdata;
  end

  // Memory strobes and ready are decoded from registered state only.
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    mem_re    = (state == XFER) && read_q;
    mem_we    = (state == XFER) && !read_q;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == XFER) begin
      mem_addr  = addr_q + ADDR_W'(cnt);
      mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
    end
  end

  // Main FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      read_q     <= 1'b0;
      func3_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      result     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            read_q  <= req_read;
            func3_q <= req_func3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= '0;
            result  <= '0;
            if (req_reject) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (read_q)
            result <= merged;
          cnt <= cnt + 2'd1;
          if (cnt == last_idx(func3_q)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= read_q ? extend(func3_q, merged) : '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an 8-bit behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [256];

  int tests = 0;
  int fails = 0;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_n;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_req(input vec_t v);
    int nstrobe;
    int bad;
    int lat;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wd;
    wait_ready(v.name);
    req_valid = 1'b1;
    req_read  = v.rd;
    req_func3 = v.f3;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nstrobe = 0;
    bad = 0;
    lat = 0;
    rdata = 'x;
    err = 1'bx;
    wd = v.wdata;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        if (mem_re !== v.rd || mem_we !== !v.rd) bad++;
        if (mem_addr !== 8'(v.addr + 8'(nstrobe))) bad++;
        if (!v.rd && nstrobe < 4 && mem_wdata !== wd[8*nstrobe +: 8]) bad++;
        nstrobe++;
      end
      if (resp_valid) begin
        lat = k;
        rdata = resp_rdata;
        err = resp_err;
        break;
      end
    end
    check({v.name, "_latency"}, lat, v.exp_err ? 1 : v.exp_n + 1);
    check({v.name, "_strobes"}, nstrobe, v.exp_n);
    check({v.name, "_strobe_content"}, bad, 0);
    check({v.name, "_rdata"}, rdata, v.exp_rdata);
    check({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    @(negedge clk);
    check({v.name, "_pulse_end"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[200] = 8'h11;
    mem[216] = 8'h60;
    mem[217] = 8'hAA;
    mem[16]  = 8'h7F;
    mem[254] = 8'h01;
    mem[255] = 8'h02;
    mem[0]   = 8'h03;
    mem[1]   = 8'h04;

    vecs[0]  = '{1'b1, 3'b010, 8'd200, 32'h0, 32'h00000011, 1'b0, 4, "lw200"};
    vecs[1]  = '{1'b1, 3'b000, 8'd217, 32'h0, 32'hFFFFFFAA, 1'b0, 1, "lb217"};
    vecs[2]  = '{1'b1, 3'b100, 8'd217, 32'h0, 32'h000000AA, 1'b0, 1, "lbu217"};
    vecs[3]  = '{1'b1, 3'b001, 8'd216, 32'h0, 32'hFFFFAA60, 1'b0, 2, "lh216"};
    vecs[4]  = '{1'b1, 3'b101, 8'd216, 32'h0, 32'h0000AA60, 1'b0, 2, "lhu216"};
    vecs[5]  = '{1'b0, 3'b010, 8'd12, 32'hDEADBEEF, 32'h0, 1'b0, 4, "sw12"};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[6]  = '{1'b1, 3'b010, 8'd254, 32'h0, 32'h0, 1'b1, 0, "lw254"};
`else
    vecs[6]  = '{1'b1, 3'b010, 8'd254, 32'h0, 32'h04030201, 1'b0, 4, "lw254"};
`endif
    vecs[7]  = '{1'b1, 3'b011, 8'd200, 32'h0, 32'h0, 1'b1, 0, "ld_f011"};
    vecs[8]  = '{1'b0, 3'b100, 8'd50, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "st_f100"};
    vecs[9]  = '{1'b1, 3'b000, 8'd16, 32'h0, 32'h0000007F, 1'b0, 1, "lb16_pos"};
    vecs[10] = '{1'b0, 3'b001, 8'd40, 32'h55551234, 32'h0, 1'b0, 2, "sh40"};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[11] = '{1'b1, 3'b001, 8'd41, 32'h0, 32'h0, 1'b1, 0, "lh41"};
`else
    vecs[11] = '{1'b1, 3'b001, 8'd41, 32'h0, 32'h00000012, 1'b0, 2, "lh41"};
`endif
    vecs[12] = '{1'b1, 3'b110, 8'd200, 32'h0, 32'h0, 1'b1, 0, "ld_f110"};
    vecs[13] = '{1'b1, 3'b111, 8'd200, 32'h0, 32'h0, 1'b1, 0, "ld_f111"};
    vecs[14] = '{1'b0, 3'b101, 8'd60, 32'hA5A5A5A5, 32'h0, 1'b1, 0, "st_f101"};
    vecs[15] = '{1'b0, 3'b000, 8'd255, 32'h000000C3, 32'h0, 1'b0, 1, "sb255"};

    // Outputs held quiet during reset.
    #12;
    check("rst_outputs",
          {24'd0, req_ready, resp_valid, resp_err, mem_re, mem_we, 3'd0}, 32'd0);
    check("rst_addr_data", {16'd0, mem_addr, mem_wdata}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) run_req(vecs[i]);

    check("sw12_mem", {mem[15], mem[14], mem[13], mem[12]}, 32'hDEADBEEF);
    check("sh40_mem", {16'd0, mem[41], mem[40]}, 32'h00001234);
    check("err_store_nowrite", {24'd0, mem[50]}, 32'd0);
    check("sb255_mem", {24'd0, mem[255]}, 32'h000000C3);

    // Reset asserted during the second XFER cycle of a word load.
    wait_ready("rst_lw");
    req_valid = 1'b1;
    req_read  = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 8'd200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_lw_pre", {22'd0, mem_re, mem_addr, 1'b0}, {22'd0, 1'b1, 8'd201, 1'b0});
    rst = 1'b1;
    #1;
    check("rst_mid_strobe", {22'd0, mem_re, mem_we, mem_addr}, 32'd0);
    check("rst_mid_ready", {30'd0, req_ready, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid || mem_re) seen++;
    end
    check("rst_no_resp", seen, 0);
    check("rst_post_ready", {31'd0, req_ready}, 32'd1);
    run_req(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte-address width of the data memory port.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid  input  1  the CPU presents a load/store request.
REQ-005 The block SHALL have port req_ready  output  1  the unit is idle and accepts a request this cycle.
REQ-006 The block SHALL have ports req_read  input  1 (1=load, 0=store), req_func3  input  3 (RISC-V width code), req_addr  input  ADDR_W, req_wdata  input  32.
REQ-007 The block SHALL have ports resp_valid  output  1 (one-cycle completion pulse), resp_rdata  output  32 (extended load data), resp_err  output  1 (request rejected).
REQ-008 The block SHALL have ports mem_addr  output  ADDR_W, mem_re  output  1, mem_we  output  1, mem_wdata  output  8, mem_rdata  input  8 (combinational read of byte at mem_addr, same cycle).

Function
REQ-009 The block SHALL implement FSM states IDLE, XFER, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-010 On req_valid & req_ready at a rising edge the block SHALL latch read, func3, addr, wdata, clear byte counter cnt to 0, and enter XFER (or RESP per REQ-016/REQ-020); req_valid outside IDLE SHALL be ignored.
REQ-011 Transfer length N SHALL be 1 for func3 000/100, 2 for 001/101, 4 for 010.
REQ-012 In XFER the block SHALL drive mem_addr = latched addr + cnt modulo 2^ADDR_W, mem_re = read, mem_we = ~read, mem_wdata = wdata byte cnt (byte 0 = bits 7:0); mem_re/mem_we SHALL be 0 in all other states.
REQ-013 For loads, the block SHALL capture mem_rdata into result byte cnt at each XFER edge; cnt SHALL increment each XFER cycle; at cnt = N-1 the FSM SHALL go to RESP.
REQ-014 In RESP resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; resp_valid SHALL be 0 in IDLE and XFER.
REQ-015 resp_rdata SHALL be: 000 sign-extend byte 0; 001 sign-extend bytes 1:0; 010 bytes 3:0; 100 zero-extend byte 0; 101 zero-extend bytes 1:0; stores and errors SHALL return 0; resp_rdata SHALL hold 0 outside RESP.
REQ-016 Illegal func3 (loads: 011,110,111; stores: any except 000,001,010) SHALL skip XFER, go directly to RESP with resp_err=1 and no memory strobe.
REQ-017 Latency SHALL be: resp_valid asserted N+1 cycles after the accepting edge; error responses 1 cycle after.
REQ-018 Back-to-back throughput SHALL be one request per N+2 cycles (IDLE cycle required between requests).

Reset
REQ-019 While rst is high, and immediately on its assertion including mid-XFER, the block SHALL force state IDLE, cnt 0, latched data 0, and outputs resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=0; an aborted request SHALL produce no response.

Configuration
REQ-020 With macro LSU_MISALIGN_TRAP_EN defined, a halfword request with addr[0]=1 or word request with addr[1:0]!=0 SHALL be rejected per REQ-016 (resp_err=1, no strobe); without it, misaligned requests SHALL complete byte-serially with address wrap per REQ-012 and resp_err=0.

Verification
REQ-021 Memory bytes 200..203 = 11,00,00,00; lw addr 200 -> mem_re on addrs 200..203 over 4 cycles, resp_valid 5 cycles after accept, resp_rdata=0x00000011.
REQ-022 Byte 217=0xAA: lb 217 -> 0xFFFFFFAA; lbu 217 -> 0x000000AA; bytes 216/217=0x60/0xAA: lh 216 -> 0xFFFFAA60, lhu 216 -> 0x0000AA60.
REQ-023 sw 0xDEADBEEF at addr 12 -> mem_we 4 cycles, addr/data 12/EF,13/BE,14/AD,15/DE; resp_valid with resp_rdata=0, resp_err=0.
REQ-024 lw addr 254: without LSU_MISALIGN_TRAP_EN -> addrs 254,255,0,1; with it -> no mem_re, resp_err=1 one cycle after accept.
REQ-025 Load func3=011 -> no strobe, resp_err=1, resp_rdata=0; store func3=100 -> same.
REQ-026 Assert rst during second XFER cycle of lw -> mem_re drops immediately, no resp_valid; after release req_ready=1 and next lb completes normally.
